timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Memory-mapped programmable down-counter that sits between the system bridge and the CPU interrupt input.
- Occupies a 3-word register window: CTRL, PRESET and COUNT.
- When a programmed interval expires and interrupts are unmasked, it drives a level interrupt request into one HWInt bit.
- Two instances are used: device-0 and device-1 interrupt sources.

Parameters:
- W, 32, counter/register data width (only 32 is verified).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- Addr  in  32  byte address from bridge; only Addr[3:2] is decoded.
- WE  in  1  word write strobe, already qualified by the bridge for this device.
- Din  in  32  write data.
- Dout  out  32  read data, combinational from Addr[3:2].
- IRQ  out  1  interrupt request, level.

Behaviour:
- Register map, selected by Addr[3:2]:
  - 0 = CTRL: [0] EN, [2:1] MODE, [3] IM; bits [31:4] always read 0.
  - 1 = PRESET: read/write.
  - 2 = COUNT: read-only; writes are ignored.
  - 3 = reads 0; writes are ignored.
- Dout is purely combinational; read latency is 0 cycles.
- Reset (sync): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, so IRQ=0.
- IRQ = irq_flag & CTRL.IM, combinational.
- Writes:
  - Applied at the clk edge when WE=1.
  - A CTRL write stores Din[3:0].
  - A CPU write to CTRL in the same cycle as an FSM update to CTRL.EN wins over the FSM.
  - Any write to CTRL or PRESET clears irq_flag. This is the acknowledge path.
- FSM states: IDLE, LOAD, CNT, INT (2-bit encoding, package constants).
- IDLE: if EN=1 -> LOAD; otherwise stay.
- LOAD: COUNT <= PRESET; -> CNT. This takes 1 cycle.
- CNT:
  - if EN=0 -> IDLE, with COUNT frozen.
  - else if COUNT > 1: COUNT <= COUNT-1, stay.
  - else (COUNT is 1 or 0): COUNT <= 0, irq_flag <= 1, -> INT.
- INT, MODE=00 (one-shot):
  - CTRL.EN <= 0 (unless overridden by a same-cycle CTRL write).
  - irq_flag is held until the software acknowledge.
  - -> IDLE.
- INT, MODE=01 (auto-reload):
  - irq_flag <= 0, so IRQ is a one-cycle pulse.
  - -> IDLE; the FSM then reloads, because EN is still 1.
- INT, MODE=1x: treated as MODE=01.
- Timing: from the EN=1 write edge to IRQ rising is PRESET+2 edges for PRESET>=1; PRESET=0 behaves as PRESET=1.
- A write to PRESET mid-count does not affect COUNT until the next LOAD.
- Clearing EN mid-count freezes COUNT. Re-enabling restarts through LOAD, so COUNT is reloaded.
- Reset asserted in any state returns to IDLE at that edge; all writes in that cycle are discarded.
- COUNT never underflows or wraps below 0.

Decomposition:
- Shared package/header (constants):
  - register offsets: CTRL=2'd0, PRESET=2'd1, COUNT=2'd2.
  - CTRL bit positions: EN=0, MODE=2:1, IM=3.
  - MODE codes: ONESHOT=2'b00, RELOAD=2'b01.
  - FSM state codes: IDLE, LOAD, CNT, INT.
- Single flat module; no sub-module is needed. The read mux and FSM fit in roughly 150 lines.

Test Plan:
- Reset defaults: hold reset 2 cycles -> Dout reads 0 at offsets 0x0, 0x4, 0x8 and 0xC; IRQ=0.
- One-shot expiry:
  - Stimulus: PRESET=5, then CTRL=0x9 (EN, IM, mode 0).
  - IRQ rises exactly 7 edges after the CTRL write and stays high; COUNT reads 0; CTRL reads 0x8.
  - Writing CTRL=0x8 drops IRQ the next cycle.
- Auto-reload:
  - Stimulus: PRESET=3, CTRL=0xB.
  - IRQ is a 1-cycle pulse, recurring every 6 cycles; COUNT sequence is 3,2,1,0 between pulses.
- Masked interrupt: PRESET=2, CTRL=0x1 -> IRQ stays 0 through expiry; a later write CTRL=0x8 still clears the flag, so IRQ stays 0.
- Pause and resume:
  - During counting with COUNT=10, write CTRL=0x8 (EN=0) -> COUNT holds 10 for 4 cycles.
  - Writing CTRL=0x9 reloads COUNT to PRESET, not 10.
- Ignored writes and mid-run reset:
  - Write COUNT=0x1234 -> COUNT is unaffected.
  - Assert reset while in CNT with a simultaneous WE to PRESET -> all registers are 0, state IDLE and PRESET=0 after the edge.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped down-counter: register offsets,
// CTRL bit positions, mode codes and FSM state encoding.
package timer_counter_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

endpackage

// File: rtl/timer_counter.sv
// Programmable down-counter with CTRL/PRESET/COUNT register window and a
// level interrupt request gated by CTRL.IM.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  Addr,
    input  logic         WE,
    input  logic [W-1:0] Din,
    output logic [W-1:0] Dout,
    output logic         IRQ
);

    logic [3:0]   r_ctrl;
    logic [W-1:0] r_preset;
    logic [W-1:0] r_count;
    logic         r_irq_flag;
    state_e       r_state;
    state_e       w_state_next;

    logic [1:0]   w_sel;
    logic [1:0]   w_mode;
    logic         w_en;
    logic         w_wr_ctrl;
    logic         w_wr_preset;
    logic         w_load;
    logic         w_dec;
    logic         w_expire;
    logic         w_oneshot_done;
    logic         w_pulse_end;
    logic         w_addr_unused;

    assign w_sel         = Addr[3:2];
    assign w_addr_unused = ^{Addr[31:4], Addr[1:0]};
    assign w_mode        = r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
    assign w_en          = r_ctrl[CTRL_EN];
    assign w_wr_ctrl     = WE && (w_sel == ADDR_CTRL);
    assign w_wr_preset   = WE && (w_sel == ADDR_PRESET);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_en) w_state_next = ST_LOAD;
            ST_LOAD: w_state_next = ST_CNT;
            ST_CNT: begin
                if (!w_en) begin
                    w_state_next = ST_IDLE;
                end else if (r_count <= W'(1)) begin
                    w_state_next = ST_INT;
                end
            end
            ST_INT:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load         = (r_state == ST_LOAD);
        w_dec          = (r_state == ST_CNT) && w_en && (r_count > W'(1));
        w_expire       = (r_state == ST_CNT) && w_en && (r_count <= W'(1));
        w_oneshot_done = (r_state == ST_INT) && (w_mode == MODE_ONESHOT);
        w_pulse_end    = (r_state == ST_INT) && (w_mode != MODE_ONESHOT);
    end

    // A CPU write to CTRL or PRESET is the acknowledge; it beats any FSM update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= Din[3:0];
            end else if (w_oneshot_done) begin
                r_ctrl[CTRL_EN] <= 1'b0;
            end

            if (w_wr_preset) begin
                r_preset <= Din;
            end

            if (w_load) begin
                r_count <= r_preset;
            end else if (w_dec) begin
                r_count <= r_count - W'(1);
            end else if (w_expire) begin
                r_count <= '0;
            end

            if (w_wr_ctrl || w_wr_preset) begin
                r_irq_flag <= 1'b0;
            end else if (w_expire) begin
                r_irq_flag <= 1'b1;
            end else if (w_pulse_end) begin
                r_irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        Dout = '0;
        case (w_sel)
            ADDR_CTRL:   Dout = {{(W-4){1'b0}}, r_ctrl};
            ADDR_PRESET: Dout = r_preset;
            ADDR_COUNT:  Dout = r_count;
            default:     Dout = '0;
        endcase
    end

    assign IRQ = r_irq_flag & r_ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: register-access vector table,
// hand-written corner sequences and randomized runs against closed-form timing.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;

    int n_tests = 0;
    int n_fail  = 0;

    timer_counter #(.W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [31:0] din;
        logic [3:0]  raddr;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        Addr = {28'h0, a};
        #1;
        d = Dout;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        Addr = {28'h0, a};
        Din  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
        Din  = '0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        WE    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        int          found;

        vecs[0] = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 4'h0, 32'h0,        4'h4, 32'h0,        1'b0};
        vecs[2] = '{1'b0, 4'h0, 32'h0,        4'h8, 32'h0,        1'b0};
        vecs[3] = '{1'b0, 4'h0, 32'h0,        4'hC, 32'h0,        1'b0};
        vecs[4] = '{1'b1, 4'h4, 32'hDEADBEEF, 4'h4, 32'hDEADBEEF, 1'b0};
        vecs[5] = '{1'b1, 4'h0, 32'hFFFFFFF6, 4'h0, 32'h6,        1'b0};
        vecs[6] = '{1'b1, 4'h8, 32'h00001234, 4'h8, 32'h0,        1'b0};
        vecs[7] = '{1'b1, 4'hC, 32'h0000FFFF, 4'hC, 32'h0,        1'b0};
        vecs[8] = '{1'b0, 4'h0, 32'h0,        4'h4, 32'hDEADBEEF, 1'b0};
        vecs[9] = '{1'b1, 4'h0, 32'h0,        4'h0, 32'h0,        1'b0};

        // Register access table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            Addr = {28'h0, vecs[i].waddr};
            Din  = vecs[i].din;
            WE   = vecs[i].we;
            tick();
            WE   = 1'b0;
            rd(vecs[i].raddr, d);
            $display("[TB] vec %0d we=%0d waddr=0x%0h din=0x%08h raddr=0x%0h dout=0x%08h irq=%0d",
                     i, vecs[i].we, vecs[i].waddr, vecs[i].din, vecs[i].raddr, d, IRQ);
            check($sformatf("vec%0d_dout", i), d, vecs[i].exp_dout);
            check($sformatf("vec%0d_irq", i), {31'h0, IRQ}, {31'h0, vecs[i].exp_irq});
        end

        // One-shot: IRQ rises exactly PRESET+2 edges after the CTRL write
        do_reset();
        wr(4'h4, 32'd5);
        wr(4'h0, 32'h9);
        for (int t = 1; t <= 10; t++) begin
            tick();
            check($sformatf("oneshot_irq_t%0d", t), {31'h0, IRQ}, (t >= 7) ? 32'h1 : 32'h0);
        end
        rd(4'h8, d); check("oneshot_count", d, 32'h0);
        rd(4'h0, d); check("oneshot_ctrl", d, 32'h8);
        wr(4'h0, 32'h8);
        check("oneshot_ack_irq", {31'h0, IRQ}, 32'h0);
        $display("[TB] seq oneshot preset=5 ctrl=0x9 done");

        // Masked: flag is set but hidden; unmasking write also acknowledges
        do_reset();
        wr(4'h4, 32'd2);
        wr(4'h0, 32'h1);
        for (int t = 1; t <= 8; t++) begin
            tick();
            check($sformatf("masked_irq_t%0d", t), {31'h0, IRQ}, 32'h0);
        end
        wr(4'h0, 32'h8);
        check("masked_unmask_irq", {31'h0, IRQ}, 32'h0);
        tick();
        check("masked_unmask_irq2", {31'h0, IRQ}, 32'h0);
        $display("[TB] seq masked preset=2 ctrl=0x1 done");

        // Pause and resume
        do_reset();
        wr(4'h4, 32'd20);
        wr(4'h0, 32'h9);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            rd(4'h8, d);
            if (d == 32'd11) begin
                found = 1;
                break;
            end
        end
        check("pause_reach_11", found, 32'h1);
        if (found == 1) begin
            wr(4'h0, 32'h8);
            rd(4'h8, d); check("pause_count_after_clear", d, 32'd10);
            wr(4'h8, 32'h1234);
            rd(4'h8, d); check("pause_count_write_ignored", d, 32'd10);
            for (int i = 0; i < 3; i++) begin
                tick();
                rd(4'h8, d); check($sformatf("pause_hold_%0d", i), d, 32'd10);
            end
            wr(4'h0, 32'h9);
            tick();
            rd(4'h8, d); check("resume_load_cycle", d, 32'd10);
            tick();
            rd(4'h8, d); check("resume_reloaded", d, 32'd20);
        end
        $display("[TB] seq pause/resume preset=20 done");

        // Reset mid-count with a simultaneous PRESET write
        do_reset();
        wr(4'h4, 32'd7);
        wr(4'h0, 32'h9);
        tick(); tick(); tick();
        reset = 1'b1;
        Addr  = 32'h4;
        Din   = 32'h55;
        WE    = 1'b1;
        tick();
        reset = 1'b0;
        WE    = 1'b0;
        rd(4'h0, d); check("rst_ctrl", d, 32'h0);
        rd(4'h4, d); check("rst_preset", d, 32'h0);
        rd(4'h8, d); check("rst_count", d, 32'h0);
        rd(4'hC, d); check("rst_reserved", d, 32'h0);
        check("rst_irq", {31'h0, IRQ}, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        rd(4'h8, d); check("rst_count_idle", d, 32'h0);
        $display("[TB] seq mid-run reset done");

        // Randomized runs against closed-form COUNT/IRQ timelines
        for (int k = 0; k < 24; k++) begin
            int p, pp, mode, im, ncyc, s, ec, ei;
            if (k == 0)      begin p = 3; mode = 1; im = 1; end
            else if (k == 1) begin p = 0; mode = 0; im = 1; end
            else if (k == 2) begin p = 1; mode = 2; im = 1; end
            else begin
                p    = int'($urandom_range(0, 9));
                mode = int'($urandom_range(0, 3));
                im   = int'($urandom_range(0, 1));
            end
            pp   = (p == 0) ? 1 : p;
            ncyc = 3 * (pp + 3) + 2;
            do_reset();
            wr(4'h4, 32'(p));
            wr(4'h0, 32'((im << 3) | (mode << 1) | 1));
            for (int t = 0; t <= ncyc; t++) begin
                if (t > 0) tick();
                if (t < 2) begin
                    ec = 0;
                end else if (mode == 0) begin
                    ec = ((t - 2) >= p) ? 0 : p - (t - 2);
                end else begin
                    s  = (t - 2) % (pp + 3);
                    ec = (s >= p) ? 0 : p - s;
                end
                if (im == 0 || t < pp + 2) ei = 0;
                else if (mode == 0) ei = 1;
                else ei = (((t - pp - 2) % (pp + 3)) == 0) ? 1 : 0;
                rd(4'h8, d);
                check($sformatf("rnd%0d_count_t%0d", k, t), d, 32'(ec));
                check($sformatf("rnd%0d_irq_t%0d", k, t), {31'h0, IRQ}, 32'(ei));
            end
            rd(4'h0, d);
            check($sformatf("rnd%0d_ctrl_end", k), d,
                  32'((im << 3) | (mode << 1) | ((mode == 0) ? 0 : 1)));
            $display("[TB] trial %0d preset=%0d mode=%0d im=%0d cycles=%0d", k, p, mode, im, ncyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
